// File: rtl/verbus_memory_responder.sv
// Verbus responder: word RAM with byte-strobe writes, LATENCY wait states and
// a mailbox register whose non-zero value raises irq.
module verbus_memory_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 0,
  parameter logic [31:0] MAILBOX_ADDRESS = 32'h80000000,
  parameter string       INIT_FILE       = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  // state | meaning
  // IDLE  | waiting for valid
  // WAIT  | counting down wait states, valid must stay high
  // RESP  | one-cycle ready pulse with registered rdata
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t        state, state_next;
  logic [3:0]    count, count_next;
  logic          do_access;
  logic          out_of_reset;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   mailbox, mailbox_next, rdata_next;
  logic          is_write, mb_hit, in_range;
  logic [AW-1:0] word_idx;
  logic          unused_addr_lsbs;

  assign is_write         = |wstrobe;
  assign mb_hit           = (address[31:2] == MAILBOX_ADDRESS[31:2]);
  assign in_range         = (32'(address[31:2]) < DEPTH);
  assign word_idx         = address[AW+1:2];
  assign unused_addr_lsbs = ^address[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      ready        <= 1'b0;
      rdata        <= '0;
      mailbox      <= '0;
      irq          <= 1'b0;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      ready        <= (state_next == RESP);
      rdata        <= rdata_next;
      mailbox      <= mailbox_next;
      irq          <= |mailbox_next;
      out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (LATENCY == 0) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            count_next = 4'(LATENCY - 1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          state_next = IDLE;
        end else if (count == 4'd0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mailbox_next = mailbox;
    rdata_next   = '0;
    if (do_access) begin
      if (is_write) begin
        if (mb_hit) begin
          for (int i = 0; i < 4; i++)
            if (wstrobe[i]) mailbox_next[8*i +: 8] = wdata[8*i +: 8];
        end
      end else if (mb_hit) begin
        rdata_next = mailbox;
      end else if (in_range) begin
        rdata_next = mem[word_idx];
      end
    end
  end

  // RAM has no reset; out_of_reset keeps a request seen during reset from writing it.
  always_ff @(posedge clk) begin
    if (out_of_reset && do_access && is_write && !mb_hit && in_range) begin
      for (int i = 0; i < 4; i++)
        if (wstrobe[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule
